// File: rtl/rtype_exec_seq.sv
// Sequencer that executes one MIPS R-type ALU instruction against an external
// register file: accept, read operands, compute, write back, then pulse done.
module rtype_exec_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] ReadReg1,
  output logic [ADDR_W-1:0] ReadReg2,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] write_data,
  output logic              RegWrite,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   rd_q;
  logic [5:0]          funct_q;
  logic                funct_ok, legal, accept;
  logic [DATA_W-1:0]   alu_out;
  logic                unused_shamt;

  // The shift-amount field has no meaning for the supported ALU ops.
  assign unused_shamt = ^instr[10:6];

  assign funct_ok = (instr[5:0] == FN_ADD) || (instr[5:0] == FN_SUB) ||
                    (instr[5:0] == FN_AND) || (instr[5:0] == FN_OR)  ||
                    (instr[5:0] == FN_NOR) || (instr[5:0] == FN_SLT);
  assign legal    = (instr[31:26] == 6'd0) && funct_ok;
  assign accept   = (state == IDLE) && instr_ready && instr_valid;

  // NOTE: always_comb assigns every output a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && legal) next_state = READ;
      READ:    next_state = EXEC;
      EXEC:    next_state = WRITE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    alu_out = '0;
    case (funct_q)
      FN_ADD:  alu_out = read_data1 + read_data2;
      FN_SUB:  alu_out = read_data1 - read_data2;
      FN_AND:  alu_out = read_data1 & read_data2;
      FN_OR:   alu_out = read_data1 | read_data2;
      FN_NOR:  alu_out = ~(read_data1 | read_data2);
      FN_SLT:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(read_data1) < $signed(read_data2))};
      default: alu_out = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      instr_ready <= 1'b0;
      ReadReg1    <= '0;
      ReadReg2    <= '0;
      WriteReg    <= '0;
      write_data  <= '0;
      RegWrite    <= 1'b0;
      result      <= '0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      rd_q        <= '0;
      funct_q     <= '0;
    end else begin
      instr_ready <= (next_state == IDLE);
      done        <= 1'b0;
      illegal     <= 1'b0;
      RegWrite    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (legal) begin
              ReadReg1 <= ADDR_W'(instr[25:21]);
              ReadReg2 <= ADDR_W'(instr[20:16]);
              rd_q     <= ADDR_W'(instr[15:11]);
              funct_q  <= instr[5:0];
            end else begin
              illegal  <= 1'b1;
            end
          end
        end
        EXEC: begin
          result     <= alu_out;
          write_data <= alu_out;
          ReadReg1   <= '0;
          ReadReg2   <= '0;
          WriteReg   <= rd_q;
          // r0 is hardwired to zero, so its write cycle runs with the enable low.
          RegWrite   <= (rd_q != '0);
        end
        WRITE: begin
          WriteReg <= '0;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_exec_seq.sv
// Self-checking bench for rtype_exec_seq: a behavioural register file plus an
// instruction-level reference model of architectural register state.
module tb_rtype_exec_seq;

  logic        CLK = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] write_data, read_data1, read_data2, result;
  logic        RegWrite, done, illegal;

  always #5 CLK = ~CLK;

  rtype_exec_seq #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK(CLK), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
    .write_data(write_data), .RegWrite(RegWrite), .read_data1(read_data1),
    .read_data2(read_data2), .result(result), .done(done), .illegal(illegal)
  );

  // Register file with one-cycle read latency and a bench-side preload port.
  logic [31:0] rf [32];
  logic        tb_we = 1'b0;
  logic [4:0]  tb_waddr = '0;
  logic [31:0] tb_wdata = '0;

  always @(posedge CLK) begin
    if (tb_we)         rf[tb_waddr] <= tb_wdata;
    else if (RegWrite) rf[WriteReg] <= write_data;
    read_data1 <= rf[ReadReg1];
    read_data2 <= rf[ReadReg2];
  end

  logic [31:0] ref_regs [32];
  logic [31:0] last_result = '0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic bit supported(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
           fn == 6'h25 || fn == 6'h27 || fn == 6'h2A;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
    case (fn)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h27:   return ~(a | b);
      6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic poke(input int r, input logic [31:0] v);
    @(negedge CLK);
    tb_we = 1'b1; tb_waddr = 5'(r); tb_wdata = v;
    @(negedge CLK);
    tb_we = 1'b0;
    ref_regs[r] = v;
  endtask

  task automatic check_rf(input string tag);
    for (int r = 0; r < 32; r++) check($sformatf("%s_r%0d", tag, r), rf[r], ref_regs[r]);
  endtask

  // Called at a falling edge with the sequencer idle; returns at the falling
  // edge where done (or the illegal follow-up) has been checked.
  task automatic run_instr(input logic [31:0] w, input bit hold_valid, input logic [31:0] next_w);
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn;
    logic [31:0] exp;
    bit          legal;
    rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; fn = w[5:0];
    legal = (w[31:26] == 6'd0) && supported(fn);
    check("ready_idle", instr_ready, 1);
    instr = w; instr_valid = 1'b1;
    @(negedge CLK);
    if (!legal) begin
      instr_valid = 1'b0; instr = $urandom();
      check("illegal_pulse", illegal, 1);
      check("illegal_ready", instr_ready, 1);
      check("illegal_regwrite", RegWrite, 0);
      check("illegal_rr1", ReadReg1, 0);
      check("illegal_rr2", ReadReg2, 0);
      check("illegal_no_done", done, 0);
      @(negedge CLK);
      check("illegal_one_cycle", illegal, 0);
      check("illegal_no_done2", done, 0);
      check("illegal_result_held", result, last_result);
      return;
    end
    exp = ref_alu(fn, ref_regs[rs], ref_regs[rt]);
    for (int c = 1; c <= 3; c++) begin
      // While busy the handshake inputs are ignored, so scramble them.
      instr_valid = hold_valid ? 1'b1 : 1'($urandom_range(1));
      instr = hold_valid ? next_w : $urandom();
      if (c == 3 && !hold_valid) instr_valid = 1'b0;
      if (c <= 2) begin
        check("read_rr1", ReadReg1, rs);
        check("read_rr2", ReadReg2, rt);
        check("read_regwrite", RegWrite, 0);
        check("busy_ready", instr_ready, 0);
        check("busy_done", done, 0);
      end else begin
        check("write_wr", WriteReg, rd);
        check("write_regwrite", RegWrite, (rd != 5'd0));
        check("write_data", write_data, exp);
        check("write_result", result, exp);
        check("write_ready", instr_ready, 0);
      end
      @(negedge CLK);
    end
    check("done_pulse", done, 1);
    check("done_ready", instr_ready, 1);
    check("done_regwrite", RegWrite, 0);
    check("done_wr", WriteReg, 0);
    check("done_result_held", result, exp);
    if (rd != 5'd0) ref_regs[rd] = exp;
    last_result = exp;
  endtask

  initial begin
    logic [5:0] fn_tab [6];
    logic [31:0] w;
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
    fn_tab[3] = 6'h25; fn_tab[4] = 6'h27; fn_tab[5] = 6'h2A;

    // Reset held two cycles with an instruction offered.
    reset = 1'b1; instr_valid = 1'b1; instr = 32'h00221820;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check("rst_ready", instr_ready, 0);
      check("rst_regwrite", RegWrite, 0);
      check("rst_rr1", ReadReg1, 0);
      check("rst_rr2", ReadReg2, 0);
      check("rst_wr", WriteReg, 0);
      check("rst_wdata", write_data, 0);
      check("rst_result", result, 0);
      check("rst_done", done, 0);
      check("rst_illegal", illegal, 0);
    end
    reset = 1'b0; instr_valid = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", instr_ready, 1);
    check("post_rst_regwrite", RegWrite, 0);

    for (int r = 0; r < 32; r++) poke(r, 32'd0);

    // add r3,r1,r2
    poke(1, 32'd5); poke(2, 32'd7);
    run_instr(32'h00221820, 1'b0, 32'd0);
    check("readback_r3", rf[3], 32'd12);

    // Wrap, sub, signed slt.
    poke(1, 32'hFFFF_FFFF); poke(2, 32'd1);
    run_instr(mk(6'd0, 5'd1, 5'd2, 5'd6, 6'h20), 1'b0, 32'd0);
    check("readback_wrap", rf[6], 32'd0);
    run_instr(mk(6'd0, 5'd2, 5'd1, 5'd4, 6'h22), 1'b0, 32'd0);
    check("readback_sub", rf[4], 32'd2);
    run_instr(mk(6'd0, 5'd1, 5'd2, 5'd5, 6'h2A), 1'b0, 32'd0);
    check("readback_slt", rf[5], 32'd1);

    // Writes to r0 are suppressed; rs==rt and rd==rs are legal.
    run_instr(mk(6'd0, 5'd1, 5'd2, 5'd0, 6'h20), 1'b0, 32'd0);
    check("readback_r0", rf[0], 32'd0);
    run_instr(mk(6'd0, 5'd2, 5'd2, 5'd2, 6'h20), 1'b0, 32'd0);
    check("readback_rd_eq_rs", rf[2], 32'd2);

    // Rejected encodings.
    run_instr(mk(6'h23, 5'd1, 5'd2, 5'd3, 6'h20), 1'b0, 32'd0);
    run_instr(mk(6'd0, 5'd1, 5'd2, 5'd3, 6'h3F), 1'b0, 32'd0);
    check_rf("after_illegal");

    // Back-to-back with reset during EXEC of the second instruction.
    run_instr(mk(6'd0, 5'd1, 5'd2, 5'd7, 6'h25), 1'b1, mk(6'd0, 5'd2, 5'd1, 5'd8, 6'h22));
    @(negedge CLK);
    instr_valid = 1'b0;
    check("b2b_rr1", ReadReg1, 2);
    check("b2b_rr2", ReadReg2, 1);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    check("abort_regwrite", RegWrite, 0);
    check("abort_done", done, 0);
    check("abort_illegal", illegal, 0);
    check("abort_result", result, 0);
    @(negedge CLK);
    check("abort_ready", instr_ready, 1);
    check("abort_done2", done, 0);
    check("abort_regwrite2", RegWrite, 0);
    last_result = 32'd0;
    check_rf("after_abort");

    // Randomised instruction stream against the reference model.
    for (int r = 1; r < 32; r++) poke(r, $urandom());
    for (int n = 0; n < 60; n++) begin
      w = mk(6'd0, 5'($urandom()), 5'($urandom()), 5'($urandom()), fn_tab[$urandom_range(5)]);
      if ($urandom_range(7) == 0) w[31:26] = 6'($urandom_range(63, 1));
      if ($urandom_range(7) == 0) w[5:0] = 6'h3F;
      run_instr(w, 1'b0, 32'd0);
    end
    check_rf("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
